// File: rtl/cpu_mem_pkg.sv
// Shared CPU memory-bus definitions: default bus widths, responder FSM encoding
// and the wait-state counter width.
package cpu_mem_pkg;

    localparam int DWIDTH_DEF     = 16;
    localparam int ADDR_WIDTH_DEF = 12;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, combinational read of the addressed word.
// With MEM_PARITY_EN defined each word carries a parity bit and a read reports a parity error.
module mem_array
    import cpu_mem_pkg::*;
#(
    parameter int DWIDTH     = DWIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DWIDTH-1:0]     wdata,
`ifdef MEM_PARITY_EN
    input  logic                  perr_inj,
    output logic                  perr,
`endif
    output logic [DWIDTH-1:0]     rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef MEM_PARITY_EN
    // Top bit of each word is the stored parity; perr_inj deliberately corrupts it.
    logic [DWIDTH:0] mem [0:DEPTH-1];
    logic [DWIDTH:0] word;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= {(^wdata) ^ perr_inj, wdata};
        end
    end

    assign word  = mem[addr];
    assign rdata = word[DWIDTH-1:0];
    assign perr  = (^word[DWIDTH-1:0]) != word[DWIDTH];
`else
    logic [DWIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
`endif

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU bus: accepts one request, waits WAIT_STATES cycles,
// accesses mem_array and pulses o_ready. Optional word parity under MEM_PARITY_EN.
module mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DWIDTH      = DWIDTH_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_ce,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DWIDTH-1:0]     i_data,
    input  logic                  i_perr_inj,
    output logic [DWIDTH-1:0]     o_data,
    output logic                  o_ready,
    output logic                  o_busy,
    output logic                  o_perr
);

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic                  accept;
    logic                  arr_go;

    logic                  req_we_p0;
    logic [ADDR_WIDTH-1:0] req_addr_p0;
    logic [DWIDTH-1:0]     req_data_p0;

    logic                  cur_we;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DWIDTH-1:0]     cur_data;
    logic                  arr_we;
    logic [DWIDTH-1:0]     arr_rdata;
    logic                  arr_perr;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        arr_go  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_ce) begin
                    accept = 1'b1;
                    cnt_n  = CNT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_n = ST_RESP;
                        arr_go  = 1'b1;
                    end else begin
                        state_n = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = ST_RESP;
                    arr_go  = 1'b1;
                end
            end
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Stage p0: request capture at acceptance (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (accept) begin
            req_we_p0   <= i_we;
            req_addr_p0 <= i_addr;
            req_data_p0 <= i_data;
        end
    end

    // With zero wait states the array is accessed on the accepting edge, before
    // the request registers hold the request, so the live bus fields are used.
    assign cur_we   = (state == ST_IDLE) ? i_we   : req_we_p0;
    assign cur_addr = (state == ST_IDLE) ? i_addr : req_addr_p0;
    assign cur_data = (state == ST_IDLE) ? i_data : req_data_p0;
    assign arr_we   = arr_go & cur_we;

`ifdef MEM_PARITY_EN
    logic req_inj_p0;
    logic cur_inj;

    always_ff @(posedge clk) begin
        if (accept) begin
            req_inj_p0 <= i_perr_inj;
        end
    end

    assign cur_inj = (state == ST_IDLE) ? i_perr_inj : req_inj_p0;

    mem_array #(
        .DWIDTH     (DWIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk      (clk),
        .we       (arr_we),
        .addr     (cur_addr),
        .wdata    (cur_data),
        .perr_inj (cur_inj),
        .perr     (arr_perr),
        .rdata    (arr_rdata)
    );
`else
    logic unused_perr_inj;
    assign unused_perr_inj = i_perr_inj;
    assign arr_perr        = 1'b0;

    mem_array #(
        .DWIDTH     (DWIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (cur_addr),
        .wdata (cur_data),
        .rdata (arr_rdata)
    );
`endif

    // Stage p1: response registers; read data holds until the next read completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            o_data <= '0;
            o_perr <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            o_perr <= 1'b0;
            if (arr_go && !cur_we) begin
                o_data <= arr_rdata;
                o_perr <= arr_perr;
            end
        end
    end

    assign o_ready = (state == ST_RESP);
    assign o_busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with one wait state, one with zero wait states.
module tb_mem_responder;

    localparam int DW = 16;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // instance with WAIT_STATES=1
    logic          ce = 1'b0, we = 1'b0, inj = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] o_data;
    logic          o_ready, o_busy, o_perr;

    // instance with WAIT_STATES=0
    logic          ce_z = 1'b0, we_z = 1'b0, inj_z = 1'b0;
    logic [AW-1:0] addr_z = '0;
    logic [DW-1:0] wdata_z = '0;
    logic [DW-1:0] o_data_z;
    logic          o_ready_z, o_busy_z, o_perr_z;

    mem_responder #(.DWIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(1)) dut (
        .clk(clk), .reset(reset), .i_ce(ce), .i_we(we), .i_addr(addr), .i_data(wdata),
        .i_perr_inj(inj), .o_data(o_data), .o_ready(o_ready), .o_busy(o_busy), .o_perr(o_perr)
    );

    mem_responder #(.DWIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .i_ce(ce_z), .i_we(we_z), .i_addr(addr_z), .i_data(wdata_z),
        .i_perr_inj(inj_z), .o_data(o_data_z), .o_ready(o_ready_z), .o_busy(o_busy_z), .o_perr(o_perr_z)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          perr;
    } exp_t;

    int checks = 0;
    int errors = 0;
    exp_t          q1[$];
    exp_t          q0[$];
    logic [DW-1:0] mem_m [int];
    logic          perr_m [int];
    logic [DW-1:0] last_rd1 = '0;
    logic [DW-1:0] last_rd0 = '0;

    function automatic logic stored_perr(input logic inj_bit);
`ifdef MEM_PARITY_EN
        return inj_bit;
`else
        return 1'b0;
`endif
    endfunction

    // Full transaction on the one-wait-state instance.
    task automatic txn1(input logic t_we, input logic [AW-1:0] t_addr,
                        input logic [DW-1:0] t_data, input logic t_inj);
        exp_t e;
        int   lat;
        @(negedge clk);
        ce = 1'b1; we = t_we; addr = t_addr; wdata = t_data; inj = t_inj;
        @(posedge clk);
        @(negedge clk);
        ce = 1'b0; we = 1'b0; inj = 1'b0;
        if (t_we) begin
            mem_m[int'(t_addr)]  = t_data;
            perr_m[int'(t_addr)] = stored_perr(t_inj);
            e.data = last_rd1;
            e.perr = 1'b0;
        end else begin
            e.data   = mem_m[int'(t_addr)];
            e.perr   = perr_m[int'(t_addr)];
            last_rd1 = e.data;
        end
        q1.push_back(e);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_accept actual=%b required=1", o_busy);
        end
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            if (o_ready === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL latency_ws1 addr=%h actual=%0d required=1", t_addr, lat);
        end
        e = q1.pop_front();
        if (lat >= 0) begin
            checks++;
            if (o_data !== e.data) begin
                errors++;
                $display("FAIL data_ws1 addr=%h we=%b actual=%h required=%h", t_addr, t_we, o_data, e.data);
            end
            checks++;
            if (o_perr !== e.perr) begin
                errors++;
                $display("FAIL perr_ws1 addr=%h actual=%b required=%b", t_addr, o_perr, e.perr);
            end
        end
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b0 || o_busy !== 1'b0 || o_perr !== 1'b0) begin
            errors++;
            $display("FAIL pulse_end_ws1 actual=%b%b%b required=000", o_ready, o_busy, o_perr);
        end
    endtask

    // Full transaction on the zero-wait-state instance.
    task automatic txn0(input logic t_we, input logic [AW-1:0] t_addr, input logic [DW-1:0] t_data);
        exp_t e;
        @(negedge clk);
        ce_z = 1'b1; we_z = t_we; addr_z = t_addr; wdata_z = t_data;
        @(posedge clk);
        @(negedge clk);
        ce_z = 1'b0; we_z = 1'b0;
        if (t_we) begin
            mem_m[int'(t_addr)]  = t_data;
            perr_m[int'(t_addr)] = 1'b0;
            e.data = last_rd0;
        end else begin
            e.data   = mem_m[int'(t_addr)];
            last_rd0 = e.data;
        end
        e.perr = 1'b0;
        q0.push_back(e);
        e = q0.pop_front();
        checks++;
        if (o_ready_z !== 1'b1 || o_busy_z !== 1'b1) begin
            errors++;
            $display("FAIL ready_ws0 addr=%h actual=%b%b required=11", t_addr, o_ready_z, o_busy_z);
        end
        checks++;
        if (o_data_z !== e.data) begin
            errors++;
            $display("FAIL data_ws0 addr=%h actual=%h required=%h", t_addr, o_data_z, e.data);
        end
        @(negedge clk);
        checks++;
        if (o_ready_z !== 1'b0 || o_busy_z !== 1'b0) begin
            errors++;
            $display("FAIL pulse_end_ws0 actual=%b%b required=00", o_ready_z, o_busy_z);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (o_data !== '0 || o_ready !== 1'b0 || o_busy !== 1'b0 || o_perr !== 1'b0) begin
            errors++;
            $display("FAIL reset_ws1 actual=%h/%b%b%b required=0000/000", o_data, o_ready, o_busy, o_perr);
        end
        checks++;
        if (o_data_z !== '0 || o_ready_z !== 1'b0 || o_busy_z !== 1'b0 || o_perr_z !== 1'b0) begin
            errors++;
            $display("FAIL reset_ws0 actual=%h/%b%b%b required=0000/000", o_data_z, o_ready_z, o_busy_z, o_perr_z);
        end
        @(negedge clk);
        reset = 1'b0;
        last_rd1 = '0;
        last_rd0 = '0;
    endtask

    task automatic test_write_read();
        txn1(1'b1, 12'h010, 16'hBEEF, 1'b0);
        txn1(1'b0, 12'h010, 16'h0000, 1'b0);
        txn1(1'b1, 12'h011, 16'h8001, 1'b0);
        txn1(1'b1, 12'hFFF, 16'h7E57, 1'b0);
        txn1(1'b0, 12'hFFF, 16'h0000, 1'b0);
        txn1(1'b0, 12'h011, 16'h0000, 1'b0);
    endtask

    task automatic test_busy_ignore();
        int n_rdy;
        exp_t e;
        txn1(1'b1, 12'h020, 16'h5A5A, 1'b0);
        @(negedge clk);
        ce = 1'b1; we = 1'b0; addr = 12'h020;
        @(posedge clk);
        @(negedge clk);
        e.data = mem_m[32'h20];
        e.perr = perr_m[32'h20];
        last_rd1 = e.data;
        q1.push_back(e);
        ce = 1'b1; we = 1'b1; addr = 12'h020; wdata = 16'hDEAD;
        n_rdy = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) ce = 1'b0;
            if (o_ready === 1'b1) begin
                n_rdy++;
                e = q1.pop_front();
                checks++;
                if (o_data !== e.data) begin
                    errors++;
                    $display("FAIL busy_read_data actual=%h required=%h", o_data, e.data);
                end
            end
        end
        we = 1'b0;
        checks++;
        if (n_rdy != 1) begin
            errors++;
            $display("FAIL busy_ready_count actual=%0d required=1", n_rdy);
        end
        txn1(1'b0, 12'h020, 16'h0000, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        int n_rdy;
        txn1(1'b1, 12'h030, 16'h0BAD, 1'b0);
        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = 12'h030; wdata = 16'h1234;
        @(posedge clk);
        #2 reset = 1'b1;
        ce = 1'b0; we = 1'b0;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_ready !== 1'b0 || o_data !== '0) begin
            errors++;
            $display("FAIL reset_mid_op actual=%b%b/%h required=00/0000", o_busy, o_ready, o_data);
        end
        @(negedge clk);
        reset = 1'b0;
        last_rd1 = '0;
        last_rd0 = '0;
        n_rdy = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (o_ready === 1'b1) n_rdy++;
        end
        checks++;
        if (n_rdy != 0) begin
            errors++;
            $display("FAIL reset_dropped_ready actual=%0d required=0", n_rdy);
        end
        txn1(1'b0, 12'h030, 16'h0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [3];
        int idx, cyc, last_cyc, n_extra;
        exp_t e;
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        for (int i = 0; i < 3; i++) txn0(1'b1, AW'(i), vals[i]);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            e.data = vals[i];
            e.perr = 1'b0;
            q0.push_back(e);
        end
        ce_z = 1'b1; we_z = 1'b0; addr_z = '0;
        idx = 0; cyc = 0; last_cyc = 0;
        while (idx < 3 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (o_ready_z === 1'b1) begin
                e = q0.pop_front();
                checks++;
                if (o_data_z !== e.data) begin
                    errors++;
                    $display("FAIL b2b_data idx=%0d actual=%h required=%h", idx, o_data_z, e.data);
                end
                if (idx > 0) begin
                    checks++;
                    if (cyc - last_cyc != 2) begin
                        errors++;
                        $display("FAIL b2b_spacing idx=%0d actual=%0d required=2", idx, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                idx++;
                addr_z = AW'(idx);
                if (idx == 3) ce_z = 1'b0;
            end
        end
        checks++;
        if (idx != 3) begin
            errors++;
            $display("FAIL b2b_count actual=%0d required=3", idx);
        end
        n_extra = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (o_ready_z === 1'b1) n_extra++;
        end
        checks++;
        if (n_extra != 0 || o_data_z !== vals[2]) begin
            errors++;
            $display("FAIL b2b_after actual=%0d/%h required=0/%h", n_extra, o_data_z, vals[2]);
        end
    endtask

    task automatic test_parity();
        txn1(1'b1, 12'h040, 16'h00FF, 1'b1);
        txn1(1'b0, 12'h040, 16'h0000, 1'b0);
        txn1(1'b1, 12'h041, 16'h00FF, 1'b0);
        txn1(1'b0, 12'h041, 16'h0000, 1'b0);
        txn1(1'b1, 12'h042, 16'h0001, 1'b1);
        txn1(1'b0, 12'h042, 16'h0000, 1'b1);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_busy_ignore();
        test_reset_mid_op();
        test_back_to_back();
        test_parity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
